// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: the fetch FSM state
// encoding, the nop word presented when no instruction is live, the PC
// increment, and a helper that forces an address onto a word boundary.
// ---------------------------------------------------------------------------
package if_fetch_pkg;

    // FETCH  : a request is outstanding and its data will be kept
    // HAVE   : an instruction is held and presented downstream
    // SQUASH : a request is outstanding but its data will be thrown away
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HAVE   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

    // Redirect targets carry byte-offset bits that instruction fetch
    // never uses; clear them so every fetch address is word aligned.
    function automatic logic [31:0] alignPc(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_pc_next.sv
// ---------------------------------------------------------------------------
// pc_next
// Program-counter register, pending-redirect register and the next-PC mux
// of the fetch stage.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_state      : current fetch FSM state
//   i_ack        : instruction-memory response strobe
//   i_redirect   : taken branch / jump this cycle
//   i_pcWrite    : downstream accepts the held instruction
//   i_target     : redirect address (low two bits ignored)
//   o_pc         : current fetch address
// ---------------------------------------------------------------------------
import if_fetch_pkg::*;

module pc_next #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  fetch_state_t i_state,
    input  logic         i_ack,
    input  logic         i_redirect,
    input  logic         i_pcWrite,
    input  logic [31:0]  i_target,
    output logic [31:0]  o_pc
);

    logic [31:0] r_pc;
    logic [31:0] r_redir;
    logic [31:0] w_target;
    logic [31:0] w_pcNext;
    logic [31:0] w_redirNext;

    assign w_target = alignPc(i_target);

    // The PC must not move while a request is outstanding, because the
    // memory holds the address until it acks. A redirect that arrives
    // before the ack is parked in r_redir and applied when the stale
    // response finally comes back; a redirect in the ack cycle itself
    // wins over anything parked earlier.
    always_comb begin
        w_pcNext    = r_pc;
        w_redirNext = r_redir;
        case (i_state)
            FETCH: begin
                if (i_redirect) begin
                    if (i_ack) begin
                        w_pcNext = w_target;
                    end else begin
                        w_redirNext = w_target;
                    end
                end
            end
            SQUASH: begin
                if (i_ack) begin
                    w_pcNext = i_redirect ? w_target : r_redir;
                end else if (i_redirect) begin
                    w_redirNext = w_target;
                end
            end
            HAVE: begin
                if (i_redirect) begin
                    w_pcNext = w_target;
                end else if (i_pcWrite) begin
                    w_pcNext = r_pc + PC_INC;
                end
            end
            default: begin
                w_pcNext = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC;
            r_redir <= 32'h0000_0000;
        end else begin
            r_pc    <= w_pcNext;
            r_redir <= w_redirNext;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
// Instruction-fetch stage with a request/ack instruction-memory port.
// One fetch is in flight at a time; the returned word is held until the
// pipeline accepts it (PCWrite) or a redirect discards it.
//   clk, rst_n  : clock, asynchronous active-low reset
//   PCWrite     : downstream accept (0 = stall)
//   Redirect    : branch taken / jump, flushes the held instruction
//   Target      : redirect address
//   imem_req    : memory request, imem_addr valid while high
//   imem_addr   : word-aligned fetch address
//   imem_ack    : memory response strobe, imem_rdata valid with it
//   imem_rdata  : returned instruction word
//   Instr_o     : instruction to IF/ID (nop when not valid)
//   PC_4_o      : address of Instr_o plus 4 (zero when not valid)
//   Valid_o     : Instr_o/PC_4_o carry a live instruction
// ---------------------------------------------------------------------------
import if_fetch_pkg::*;

module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        Redirect,
    input  logic [31:0] Target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr_o,
    output logic [31:0] PC_4_o,
    output logic        Valid_o
);

    fetch_state_t r_state;
    fetch_state_t w_stateNext;
    logic [31:0]  r_ibuf;
    logic [31:0]  w_pc;
    logic         w_valid;

    pc_next #(
        .RESET_PC (RESET_PC)
    ) u_pcNext (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_state    (r_state),
        .i_ack      (imem_ack),
        .i_redirect (Redirect),
        .i_pcWrite  (PCWrite),
        .i_target   (Target),
        .o_pc       (w_pc)
    );

    // A redirect seen while a request is outstanding turns the request
    // into a squash, so its data can never be presented downstream.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            FETCH: begin
                if (imem_ack && !Redirect) begin
                    w_stateNext = HAVE;
                end else if (Redirect && !imem_ack) begin
                    w_stateNext = SQUASH;
                end
            end
            SQUASH: begin
                if (imem_ack) begin
                    w_stateNext = FETCH;
                end
            end
            HAVE: begin
                if (Redirect || PCWrite) begin
                    w_stateNext = FETCH;
                end
            end
            default: begin
                w_stateNext = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_ibuf  <= NOP_INSTR;
        end else begin
            r_state <= w_stateNext;
            if (r_state == FETCH && imem_ack && !Redirect) begin
                r_ibuf <= imem_rdata;
            end
        end
    end

    // In HAVE the PC still points at the held instruction, so PC_4_o is
    // simply pc+4 (wrapping naturally at 2^32).
    assign w_valid   = (r_state == HAVE);
    assign Valid_o   = w_valid;
    assign Instr_o   = w_valid ? r_ibuf : NOP_INSTR;
    assign PC_4_o    = w_valid ? (w_pc + PC_INC) : 32'h0000_0000;
    // Gating with rst_n drops the request the instant reset asserts,
    // abandoning whatever was in flight.
    assign imem_req  = rst_n && (r_state != HAVE);
    assign imem_addr = w_pc;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
// Self-checking bench for if_fetch. Expected instructions are queued when
// the accepting ack is driven and compared when Valid_o rises.
// ---------------------------------------------------------------------------
module tb_if_fetch;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } expItem_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        PCWrite;
   logic        Redirect;
   logic [31:0] Target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] Instr_o;
   logic [31:0] PC_4_o;
   logic        Valid_o;

   int checkCount = 0;
   int passCount  = 0;
   expItem_t expQ[$];
   logic prevValid = 1'b0;

   if_fetch dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .PCWrite    (PCWrite),
      .Redirect   (Redirect),
      .Target     (Target),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .Instr_o    (Instr_o),
      .PC_4_o     (PC_4_o),
      .Valid_o    (Valid_o)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle worth of inputs and returns at the following negedge
   task automatic applyStimulus(input logic pcw, input logic red, input logic [31:0] tgt,
                                input logic ack, input logic [31:0] rdata);
      PCWrite    = pcw;
      Redirect   = red;
      Target     = tgt;
      imem_ack   = ack;
      imem_rdata = rdata;
      @(negedge clk);
   endtask

   task automatic pushExp(input logic [31:0] instr, input logic [31:0] pc4);
      expItem_t e;
      e.instr = instr;
      e.pc4   = pc4;
      expQ.push_back(e);
   endtask

   // Scoreboard consumer: each rising Valid_o is one newly presented instruction
   always @(negedge clk) begin
      expItem_t e;
      if (Valid_o && !prevValid) begin
         if (expQ.size() == 0) begin
            checkOutput("sbUnexpected", {31'b0, Valid_o}, 32'd0);
         end else begin
            e = expQ.pop_front();
            checkOutput("sbInstr", Instr_o, e.instr);
            checkOutput("sbPc4", PC_4_o, e.pc4);
         end
      end
      prevValid = Valid_o;
   end

   // Directed scenarios covering fetch, stall, redirect, squash, wrap and reset
   initial begin
      rst_n      = 1'b0;
      PCWrite    = 1'b0;
      Redirect   = 1'b0;
      Target     = 32'h0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      repeat (2) @(negedge clk);
      checkOutput("rstReq", {31'b0, imem_req}, 32'd0);
      checkOutput("rstValid", {31'b0, Valid_o}, 32'd0);
      checkOutput("rstInstr", Instr_o, 32'h0);
      checkOutput("rstPc4", PC_4_o, 32'h0);
      rst_n = 1'b1;
      #1;
      checkOutput("firstReq", {31'b0, imem_req}, 32'd1);
      checkOutput("firstAddr", imem_addr, 32'h0);

      // Basic fetch: one wait cycle, ack, then consume
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("waitAddr", imem_addr, 32'h0);
      checkOutput("waitValid", {31'b0, Valid_o}, 32'd0);
      pushExp(32'h8C01_0004, 32'h4);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h8C01_0004);
      checkOutput("haveValid", {31'b0, Valid_o}, 32'd1);
      checkOutput("haveReq", {31'b0, imem_req}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("nextAddr", imem_addr, 32'h4);
      checkOutput("nextReq", {31'b0, imem_req}, 32'd1);
      checkOutput("nextValid", {31'b0, Valid_o}, 32'd0);

      // Stall for five cycles while holding an instruction
      pushExp(32'h1111_1111, 32'h8);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
         checkOutput("stallInstr", Instr_o, 32'h1111_1111);
         checkOutput("stallPc4", PC_4_o, 32'h8);
         checkOutput("stallReq", {31'b0, imem_req}, 32'd0);
      end
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("stallRelease", imem_addr, 32'h8);

      // Redirect while holding, PCWrite also high (redirect wins)
      pushExp(32'h2222_2222, 32'hC);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
      applyStimulus(1'b1, 1'b1, 32'h0000_0043, 1'b0, 32'h0);
      checkOutput("redirValid", {31'b0, Valid_o}, 32'd0);
      checkOutput("redirAddr", imem_addr, 32'h40);
      checkOutput("redirReq", {31'b0, imem_req}, 32'd1);

      // Redirect during an outstanding fetch, a second redirect, late ack
      applyStimulus(1'b1, 1'b1, 32'h100, 1'b0, 32'h0);
      checkOutput("squashHoldAddr", imem_addr, 32'h40);
      checkOutput("squashReq", {31'b0, imem_req}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h200, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
      checkOutput("squashAddr", imem_addr, 32'h200);
      checkOutput("squashValid", {31'b0, Valid_o}, 32'd0);
      pushExp(32'h3333_3333, 32'h204);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("afterSquash", imem_addr, 32'h204);

      // Redirect coinciding with ack, then wrap at the top of memory
      applyStimulus(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'hBADB_AD00);
      checkOutput("coValid", {31'b0, Valid_o}, 32'd0);
      checkOutput("coAddr", imem_addr, 32'hFFFF_FFFC);
      pushExp(32'h4444_4444, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
      checkOutput("wrapPc4", PC_4_o, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("wrapAddr", imem_addr, 32'h0);

      // Reset during an outstanding request, with the ack arriving in reset
      applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 32'h0);
      checkOutput("preRstAddr", imem_addr, 32'h300);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("rstDropReq", {31'b0, imem_req}, 32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h5555_5555);
      checkOutput("inRstValid", {31'b0, Valid_o}, 32'd0);
      imem_ack = 1'b0;
      rst_n    = 1'b1;
      #1;
      checkOutput("postRstAddr", imem_addr, 32'h0);
      checkOutput("postRstReq", {31'b0, imem_req}, 32'd1);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("lateAckHidden", {31'b0, Valid_o}, 32'd0);
      pushExp(32'h6666_6666, 32'h4);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
      applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("restartAddr", imem_addr, 32'h4);

      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      checkOutput("sbEmpty", expQ.size(), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
